// File: rtl/seven_seg_scanner_pkg.sv
// Shared types and constants for the multiplexed 7-segment scanner:
// state encoding, segment bit order and the hex-to-segment table.
package seven_seg_scanner_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G - SEG_A + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } state_t;

  // Entry 15 sits in the most significant slot, entry 0 in the least.
  localparam logic [16*SEG_W-1:0] SEG_ROM = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] nib);
    return SEG_ROM[SEG_W*int'(nib) +: SEG_W];
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Update channel between the register logic (master) and the scanner (slave).
interface seven_seg_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  upd_valid;
  logic                  upd_ready;
  logic [4*DIGITS-1:0]   upd_value;
  logic [DIGITS-1:0]     upd_dp;

  modport master (output upd_valid, output upd_value, output upd_dp, input upd_ready);
  modport slave  (input upd_valid, input upd_value, input upd_dp, output upd_ready);
endinterface

// File: rtl/seven_seg_scanner_scan_timer.sv
// Loadable down-counter for the scanner phases; tc flags the last cycle of a phase.
module seven_seg_scanner_scan_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Counter: clear wins over load, then count down and hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == '0);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment scanner: blank/on slots per digit, frame-aligned
// commit of shadowed updates, leading-zero suppression and registered outputs.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               lz_en,
  seven_seg_scanner_if.slave upd,
  output logic [SEG_W-1:0]   segment,
  output logic               dp,
  output logic [DIGITS-1:0]  digit_en,
  output logic               frame_done
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(((ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES) + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LOAD    = CW'(ON_CYCLES - 1);

  state_t                state_r, state_nx;
  logic [IW-1:0]         idx_r, idx_nx;
  logic                  tmr_clr_s, tmr_load_s, tmr_tc_s, wrap_s, commit_s, xfer_s;
  logic [CW-1:0]         tmr_val_s;
  logic [4*DIGITS-1:0]   sh_value_r, act_value_r;
  logic [DIGITS-1:0]     sh_dp_r, act_dp_r, supp_s, den_nx;
  logic                  pending_r, dp_nx, zrun_s;
  logic [SEG_W-1:0]      seg_nx;
  logic [3:0]            nib_s;

  seven_seg_scanner_scan_timer #(.W(CW)) u_scan_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr_s),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // FSM state and digit index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
    end
  end

  // Next-state logic; every state change reloads the phase timer.
  always_comb begin
    state_nx   = state_r;
    idx_nx     = idx_r;
    tmr_clr_s  = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    wrap_s     = 1'b0;
    if (!enable) begin
      state_nx  = ST_IDLE;
      idx_nx    = '0;
      tmr_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx   = ST_BLANK;
          idx_nx     = '0;
          tmr_load_s = 1'b1;
          tmr_val_s  = BLANK_LOAD;
        end
        ST_BLANK: begin
          if (tmr_tc_s) begin
            state_nx   = ST_ON;
            tmr_load_s = 1'b1;
            tmr_val_s  = ON_LOAD;
          end else begin
            state_nx = ST_BLANK;
          end
        end
        ST_ON: begin
          if (tmr_tc_s) begin
            state_nx   = ST_BLANK;
            tmr_load_s = 1'b1;
            tmr_val_s  = BLANK_LOAD;
            if (idx_r == LAST_IDX) begin
              idx_nx = '0;
              wrap_s = 1'b1;
            end else begin
              idx_nx = idx_r + IW'(1'b1);
            end
          end else begin
            state_nx = ST_ON;
          end
        end
        default: begin
          state_nx  = ST_IDLE;
          idx_nx    = '0;
          tmr_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Entry into BLANK(0) is the only point where the display contents change.
  assign commit_s      = enable && ((state_r == ST_IDLE) || wrap_s);
  assign xfer_s        = upd.upd_valid && !pending_r;
  assign upd.upd_ready = !pending_r;

  // Shadow/active value registers and the pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value_r  <= '0;
      sh_dp_r     <= '0;
      act_value_r <= '0;
      act_dp_r    <= '0;
      pending_r   <= 1'b0;
    end else if (commit_s && pending_r) begin
      act_value_r <= sh_value_r;
      act_dp_r    <= sh_dp_r;
      pending_r   <= 1'b0;
    end else if (xfer_s) begin
      sh_value_r <= upd.upd_value;
      sh_dp_r    <= upd.upd_dp;
      pending_r  <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Leading-zero mask: a digit is blanked while all digits above it and itself are zero.
  always_comb begin
    zrun_s = 1'b1;
    supp_s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun_s = zrun_s & (act_value_r[4*i +: 4] == 4'h0);
      if (i != 0) begin
        supp_s[i] = lz_en & zrun_s;
      end else begin
        supp_s[i] = 1'b0;
      end
    end
  end

  // Output decode from the next state so outputs switch on the same edge as the state.
  always_comb begin
    seg_nx = '0;
    dp_nx  = 1'b0;
    den_nx = '0;
    nib_s  = act_value_r[{idx_nx, 2'b00} +: 4];
    if (state_nx == ST_ON) begin
      den_nx = {{(DIGITS-1){1'b0}}, 1'b1} << idx_nx;
      dp_nx  = act_dp_r[idx_nx];
      seg_nx = supp_s[idx_nx] ? '0 : seg_decode(nib_s);
    end else begin
      den_nx = '0;
    end
  end

  // Registered display outputs and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment    <= '0;
      dp         <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      segment    <= seg_nx;
      dp         <= dp_nx;
      digit_en   <= den_nx;
      frame_done <= wrap_s;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2.
module tb_seven_seg_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       lz_en;
  logic [6:0] segment;
  logic       dp;
  logic [3:0] digit_en;
  logic       frame_done;
  int         n_cmp = 0;
  int         n_err = 0;

  seven_seg_scanner_if #(.DIGITS(4)) bus ();

  seven_seg_scanner #(.DIGITS(4), .ON_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .lz_en      (lz_en),
    .upd        (bus),
    .segment    (segment),
    .dp         (dp),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One slot: two blank cycles then four lit cycles of digit d.
  task automatic slot(input int d, input logic [6:0] s, input logic p, input logic fd, input logic rdy);
    @(negedge clk);
    chk($sformatf("d%0d_blank1_den", d), 32'(digit_en), 32'h0);
    chk($sformatf("d%0d_blank1_seg", d), 32'(segment), 32'h0);
    chk($sformatf("d%0d_frame_done", d), 32'(frame_done), 32'(fd));
    @(negedge clk);
    chk($sformatf("d%0d_blank2_den", d), 32'(digit_en), 32'h0);
    chk($sformatf("d%0d_blank2_fd", d), 32'(frame_done), 32'h0);
    chk($sformatf("d%0d_ready", d), 32'(bus.upd_ready), 32'(rdy));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("d%0d_on%0d_den", d, k), 32'(digit_en), 32'h1 << d);
      chk($sformatf("d%0d_on%0d_seg", d, k), 32'(segment), 32'(s));
      chk($sformatf("d%0d_on%0d_dp", d, k), 32'(dp), 32'(p));
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; lz_en = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_value = 16'h0000; bus.upd_dp = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(segment), 32'h0);
    chk("rst_dp", 32'(dp), 32'h0);
    chk("rst_den", 32'(digit_en), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_ready", 32'(bus.upd_ready), 32'h1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_den", 32'(digit_en), 32'h0);
    chk("idle_seg", 32'(segment), 32'h0);

    // Transfer while idle, then start scanning.
    bus.upd_valid = 1'b1; bus.upd_value = 16'h1234; bus.upd_dp = 4'h0;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    chk("idle_xfer_ready", 32'(bus.upd_ready), 32'h0);
    chk("idle_xfer_den", 32'(digit_en), 32'h0);
    enable = 1'b1;
    slot(0, 7'h66, 1'b0, 1'b0, 1'b1);
    slot(1, 7'h4F, 1'b0, 1'b0, 1'b1);
    slot(2, 7'h5B, 1'b0, 1'b0, 1'b1);
    slot(3, 7'h06, 1'b0, 1'b0, 1'b1);

    // Frame 2: mid-frame offer of FFFF, then a second value held under backpressure.
    slot(0, 7'h66, 1'b0, 1'b1, 1'b1);
    bus.upd_valid = 1'b1; bus.upd_value = 16'hFFFF; bus.upd_dp = 4'h0;
    slot(1, 7'h4F, 1'b0, 1'b0, 1'b0);
    bus.upd_value = 16'h9876; bus.upd_dp = 4'b0101;
    slot(2, 7'h5B, 1'b0, 1'b0, 1'b0);
    slot(3, 7'h06, 1'b0, 1'b0, 1'b0);

    // Frame 3: FFFF committed; the held 9876 transfers right after.
    slot(0, 7'h71, 1'b0, 1'b1, 1'b0);
    bus.upd_valid = 1'b0;
    slot(1, 7'h71, 1'b0, 1'b0, 1'b0);
    slot(2, 7'h71, 1'b0, 1'b0, 1'b0);
    slot(3, 7'h71, 1'b0, 1'b0, 1'b0);

    // Frame 4: 9876 with dp on digits 0 and 2; queue 0050 with suppression.
    slot(0, 7'h7D, 1'b1, 1'b1, 1'b1);
    lz_en = 1'b1;
    bus.upd_valid = 1'b1; bus.upd_value = 16'h0050; bus.upd_dp = 4'b1000;
    slot(1, 7'h07, 1'b0, 1'b0, 1'b0);
    bus.upd_valid = 1'b0;
    slot(2, 7'h7F, 1'b1, 1'b0, 1'b0);
    slot(3, 7'h6F, 1'b0, 1'b0, 1'b0);

    // Frame 5: 0050, digits 3 and 2 blank, dp still shown on digit 3.
    slot(0, 7'h3F, 1'b0, 1'b1, 1'b1);
    bus.upd_valid = 1'b1; bus.upd_value = 16'h0000; bus.upd_dp = 4'h0;
    slot(1, 7'h6D, 1'b0, 1'b0, 1'b0);
    bus.upd_valid = 1'b0;
    slot(2, 7'h00, 1'b0, 1'b0, 1'b0);
    slot(3, 7'h00, 1'b1, 1'b0, 1'b0);

    // Frame 6: 0000, only digit 0 lit; disable during digit 2 with 0A00 pending.
    slot(0, 7'h3F, 1'b0, 1'b1, 1'b1);
    bus.upd_valid = 1'b1; bus.upd_value = 16'h0A00; bus.upd_dp = 4'h0;
    slot(1, 7'h00, 1'b0, 1'b0, 1'b0);
    bus.upd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("dis_before_den", 32'(digit_en), 32'h4);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_den", 32'(digit_en), 32'h0);
    chk("dis_seg", 32'(segment), 32'h0);
    chk("dis_ready", 32'(bus.upd_ready), 32'h0);
    repeat (4) @(negedge clk);
    chk("dis_hold_den", 32'(digit_en), 32'h0);

    // Re-enable: restart at BLANK(0) and commit 0A00 there.
    enable = 1'b1;
    slot(0, 7'h3F, 1'b0, 1'b0, 1'b1);
    slot(1, 7'h3F, 1'b0, 1'b0, 1'b1);
    bus.upd_valid = 1'b1; bus.upd_value = 16'h1111; bus.upd_dp = 4'hF;
    slot(2, 7'h77, 1'b0, 1'b0, 1'b0);
    bus.upd_valid = 1'b0;

    // Asynchronous reset in the middle of an ON phase drops everything at once.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 32'(segment), 32'h0);
    chk("arst_den", 32'(digit_en), 32'h0);
    chk("arst_dp", 32'(dp), 32'h0);
    chk("arst_fd", 32'(frame_done), 32'h0);
    chk("arst_ready", 32'(bus.upd_ready), 32'h1);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_den", 32'(digit_en), 32'h0);
    chk("post_rst_seg", 32'(segment), 32'h0);
    chk("post_rst_ready", 32'(bus.upd_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
